// File: rtl/tile_sequencer.sv
// Purpose: sequences one tile multiply: streams (wc+1)(wl+1)(xl+1) operand beats,
//          waits LAT cycles for the multiplier to drain, then pulses done.
// Latency: start sampled in IDLE -> first beat next cycle; done LAT+1 cycles after last beat.
// Backpressure: enable low freezes all state (counters, FSM, y_valid) with strobes held 0.
// Ports: clk/reset (sync, active-high), enable, start, cfg_* (latched on start),
//        clear_out -> y_valid (1-cycle delayed), busy/done status, stream_en,
//        w_switch/x_switch line strobes, ind_* beat indices, rd/wr memory modes.
module tile_sequencer #(
  parameter int ARRAY = 8,
  parameter int CW    = 6,
  parameter int LW    = 3,
  parameter int LAT   = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic [CW-1:0]    cfg_wc,
  input  logic [LW-1:0]    cfg_wl,
  input  logic [LW-1:0]    cfg_xl,
  input  logic [3:0]       cfg_mode,
  input  logic [ARRAY-1:0] clear_out,
  output logic             busy,
  output logic             done,
  output logic             stream_en,
  output logic             w_switch,
  output logic             x_switch,
  output logic [CW-1:0]    ind_wc,
  output logic [LW-1:0]    ind_wl,
  output logic [LW-1:0]    ind_xl,
  output logic [1:0]       rd_mode_x,
  output logic [1:0]       rd_mode_w,
  output logic [2:0]       wr_mode,
  output logic [ARRAY-1:0] y_valid
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [7:0] LAT_CNT = 8'(LAT);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    wc_q, wc_d;
  logic [LW-1:0]    wl_q, wl_d;
  logic [LW-1:0]    xl_q, xl_d;
  // Only transpose X, transpose W and accumulate matter here.
  logic             tx_q, tx_d;
  logic             tw_q, tw_d;
  logic             acc_q, acc_d;
  logic [CW-1:0]    cnt_wc_q, cnt_wc_d;
  logic [LW-1:0]    cnt_wl_q, cnt_wl_d;
  logic [LW-1:0]    cnt_xl_q, cnt_xl_d;
  logic [7:0]       drain_q, drain_d;
  logic [ARRAY-1:0] y_valid_q;
  logic             last_beat;

  // ReLU is applied by the result path, not by the sequencer.
  logic unused_relu;
  assign unused_relu = cfg_mode[1];

  assign stream_en = enable && (state_q == S_STREAM);
  assign w_switch  = stream_en && (cnt_wc_q == wc_q);
  assign x_switch  = w_switch && (cnt_wl_q == wl_q);
  assign last_beat = x_switch && (cnt_xl_q == xl_q);

  assign busy      = (state_q == S_STREAM) || (state_q == S_DRAIN);
  // Gated by enable so a stalled DONE cycle yields exactly one visible pulse.
  assign done      = enable && (state_q == S_DONE);
  assign ind_wc    = cnt_wc_q;
  assign ind_wl    = cnt_wl_q;
  assign ind_xl    = cnt_xl_q;
  assign rd_mode_x = stream_en ? (tx_q ? 2'd3 : 2'd1) : 2'd0;
  assign rd_mode_w = stream_en ? (tw_q ? 2'd3 : 2'd1) : 2'd0;
  assign wr_mode   = busy ? {1'b1, (acc_q ? 2'b10 : 2'b01)} : 3'd0;
  assign y_valid   = y_valid_q;

  always_comb begin
    state_d  = state_q;
    wc_d     = wc_q;
    wl_d     = wl_q;
    xl_d     = xl_q;
    tx_d     = tx_q;
    tw_d     = tw_q;
    acc_d    = acc_q;
    cnt_wc_d = cnt_wc_q;
    cnt_wl_d = cnt_wl_q;
    cnt_xl_d = cnt_xl_q;
    drain_d  = drain_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          wc_d     = cfg_wc;
          wl_d     = cfg_wl;
          xl_d     = cfg_xl;
          tx_d     = cfg_mode[3];
          tw_d     = cfg_mode[2];
          acc_d    = cfg_mode[0];
          cnt_wc_d = '0;
          cnt_wl_d = '0;
          cnt_xl_d = '0;
          state_d  = S_STREAM;
        end
      end
      S_STREAM: begin
        // Nested wrap: cell -> W line -> X line. The last beat wraps every
        // counter to zero, leaving them clean for DRAIN and the next job.
        cnt_wc_d = w_switch ? '0 : cnt_wc_q + CW'(1);
        if (w_switch) cnt_wl_d = x_switch ? '0 : cnt_wl_q + LW'(1);
        if (x_switch) cnt_xl_d = last_beat ? '0 : cnt_xl_q + LW'(1);
        if (last_beat) begin
          state_d = S_DRAIN;
          drain_d = LAT_CNT;
        end
      end
      S_DRAIN: begin
        drain_d = drain_q - 8'd1;
        if (drain_q == 8'd1) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      wc_q      <= '0;
      wl_q      <= '0;
      xl_q      <= '0;
      tx_q      <= 1'b0;
      tw_q      <= 1'b0;
      acc_q     <= 1'b0;
      cnt_wc_q  <= '0;
      cnt_wl_q  <= '0;
      cnt_xl_q  <= '0;
      drain_q   <= '0;
      y_valid_q <= '0;
    end else if (enable) begin
      state_q   <= state_d;
      wc_q      <= wc_d;
      wl_q      <= wl_d;
      xl_q      <= xl_d;
      tx_q      <= tx_d;
      tw_q      <= tw_d;
      acc_q     <= acc_d;
      cnt_wc_q  <= cnt_wc_d;
      cnt_wl_q  <= cnt_wl_d;
      cnt_xl_q  <= cnt_xl_d;
      drain_q   <= drain_d;
      y_valid_q <= clear_out;
    end
  end

endmodule

// File: tb/tb_tile_sequencer.sv
// Purpose: self-checking bench for tile_sequencer; expected beats and done
//          cycles are queued when each job is launched and popped as the DUT emits them.
// Ports: none (top-level bench).
module tb_tile_sequencer;
  localparam int ARRAY = 8;
  localparam int CW    = 6;
  localparam int LW    = 3;
  localparam int LAT   = 9;

  logic             clk = 1'b0;
  logic             reset, enable, start;
  logic [CW-1:0]    cfg_wc;
  logic [LW-1:0]    cfg_wl, cfg_xl;
  logic [3:0]       cfg_mode;
  logic [ARRAY-1:0] clear_out;
  logic             busy, done, stream_en, w_switch, x_switch;
  logic [CW-1:0]    ind_wc;
  logic [LW-1:0]    ind_wl, ind_xl;
  logic [1:0]       rd_mode_x, rd_mode_w;
  logic [2:0]       wr_mode;
  logic [ARRAY-1:0] y_valid;

  tile_sequencer #(.ARRAY(ARRAY), .CW(CW), .LW(LW), .LAT(LAT)) dut (
    .clk(clk), .reset(reset), .enable(enable), .start(start),
    .cfg_wc(cfg_wc), .cfg_wl(cfg_wl), .cfg_xl(cfg_xl), .cfg_mode(cfg_mode),
    .clear_out(clear_out), .busy(busy), .done(done), .stream_en(stream_en),
    .w_switch(w_switch), .x_switch(x_switch), .ind_wc(ind_wc), .ind_wl(ind_wl),
    .ind_xl(ind_xl), .rd_mode_x(rd_mode_x), .rd_mode_w(rd_mode_w),
    .wr_mode(wr_mode), .y_valid(y_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    int            c;
    logic [CW-1:0] iwc;
    logic [LW-1:0] iwl;
    logic [LW-1:0] ixl;
    logic          ws;
    logic          xs;
    logic [1:0]    rx;
    logic [1:0]    rw;
  } beat_t;

  beat_t            beat_q[$];
  int               done_q[$];
  beat_t            mb;
  int               md;
  logic             mon_on = 1'b0;
  logic             exp_busy = 1'b0;
  logic [2:0]       exp_wr = 3'd0;
  logic [ARRAY-1:0] exp_y = '0;

  // y_valid reference: clear_out as seen at the last enabled edge.
  always @(posedge clk) begin
    if (reset) exp_y <= '0;
    else if (enable) exp_y <= clear_out;
  end

  always @(negedge clk) begin
    if (mon_on) begin
      chk("busy", busy, exp_busy);
      chk("wr_mode", wr_mode, exp_busy ? exp_wr : 3'd0);
      chk("y_valid", y_valid, exp_y);
      if (stream_en) begin
        if (beat_q.size() == 0) begin
          chk("unexpected_beat", stream_en, 0);
        end else begin
          mb = beat_q.pop_front();
          chk("beat_cycle", cyc, mb.c);
          chk("ind_wc", ind_wc, mb.iwc);
          chk("ind_wl", ind_wl, mb.iwl);
          chk("ind_xl", ind_xl, mb.ixl);
          chk("switches", {w_switch, x_switch}, {mb.ws, mb.xs});
          chk("rd_modes", {rd_mode_x, rd_mode_w}, {mb.rx, mb.rw});
        end
      end else begin
        chk("idle_strobes", {w_switch, x_switch, rd_mode_x, rd_mode_w}, 0);
        if (!exp_busy) chk("idle_ind", {ind_wc, ind_wl, ind_xl}, 0);
      end
      if (done) begin
        if (done_q.size() == 0) begin
          chk("unexpected_done", done, 0);
        end else begin
          md = done_q.pop_front();
          chk("done_cycle", cyc, md);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    clear_out = ARRAY'($urandom);
  endtask

  // Launch one job in the current (IDLE) cycle and run it to the following IDLE cycle.
  // pause: enable low for pause_len cycles after beat pause_after.
  // ghost_at: relative cycle in which a spurious start with random cfg is driven.
  // rst_at: relative cycle in which reset is pulsed (0 = never).
  task automatic run_job(input int wc, input int wl, input int xl, input logic [3:0] mode,
                         input int pause_after, input int pause_len,
                         input int ghost_at, input int rst_at);
    int a, n, dur, i;
    beat_t b;
    n = (wc + 1) * (wl + 1) * (xl + 1);
    a = cyc;
    i = 0;
    for (int x = 0; x <= xl; x++)
      for (int l = 0; l <= wl; l++)
        for (int c = 0; c <= wc; c++) begin
          i++;
          b.c   = a + i + ((pause_len > 0 && i > pause_after) ? pause_len : 0);
          b.iwc = CW'(c);
          b.iwl = LW'(l);
          b.ixl = LW'(x);
          b.ws  = (c == wc);
          b.xs  = (c == wc) && (l == wl);
          b.rx  = mode[3] ? 2'd3 : 2'd1;
          b.rw  = mode[2] ? 2'd3 : 2'd1;
          beat_q.push_back(b);
        end
    if (rst_at == 0) done_q.push_back(a + n + LAT + 1 + pause_len);
    cfg_wc   = CW'(wc);
    cfg_wl   = LW'(wl);
    cfg_xl   = LW'(xl);
    cfg_mode = mode;
    start    = 1'b1;
    exp_wr   = {1'b1, (mode[0] ? 2'b10 : 2'b01)};
    dur      = n + LAT + pause_len + 1;
    for (int r = 1; r <= dur; r++) begin
      tick();
      start    = (r == ghost_at);
      cfg_wc   = CW'($urandom);
      cfg_wl   = LW'($urandom);
      cfg_xl   = LW'($urandom);
      cfg_mode = 4'($urandom);
      enable   = !(pause_len > 0 && r > pause_after && r <= pause_after + pause_len);
      exp_busy = (r <= n + LAT + pause_len);
      if (rst_at != 0 && r == rst_at) reset = 1'b1;
      if (rst_at != 0 && r == rst_at + 1) begin
        reset    = 1'b0;
        exp_busy = 1'b0;
        beat_q.delete();
        done_q.delete();
        break;
      end
    end
    tick();
    start    = 1'b0;
    enable   = 1'b1;
    exp_busy = 1'b0;
    if (rst_at == 0) begin
      chk("beats_left", beat_q.size(), 0);
      chk("done_left", done_q.size(), 0);
    end
  endtask

  initial begin
    reset     = 1'b1;
    enable    = 1'b1;
    start     = 1'b0;
    cfg_wc    = '0;
    cfg_wl    = '0;
    cfg_xl    = '0;
    cfg_mode  = '0;
    clear_out = '0;
    tick();
    mon_on = 1'b1;
    // Reset held with start asserted and clear_out toggling: everything stays 0.
    start = 1'b1;
    repeat (3) tick();
    start = 1'b0;
    reset = 1'b0;
    tick();
    tick();

    run_job(3, 1, 1, 4'b0000, 0, 0, 0, 0);   // 16 beats, done 26 cycles after start
    run_job(0, 0, 0, 4'b1111, 0, 0, 0, 0);   // single beat, both strobes
    run_job(2, 3, 0, 4'b1001, 0, 0, 0, 0);   // non-square, 12 beats
    run_job(3, 1, 1, 4'b0101, 6, 5, 0, 0);   // 5-cycle stall after beat 6
    run_job(3, 1, 1, 4'b0100, 0, 0, 5, 0);   // spurious start mid-stream
    run_job(3, 1, 1, 4'b0110, 0, 0, 0, 3);   // reset during beat 3
    run_job(1, 1, 0, 4'b1000, 0, 0, 0, 0);   // fresh job after abort
    run_job(4, 0, 2, 4'b0001, 0, 0, 0, 0);   // back-to-back start
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/tile_sequencer.md
TILE_SEQUENCER -- requirements
Module: tile_sequencer

Interface
REQ-001 Parameter ARRAY, default 8: systolic array edge; sets the width of the y_valid and clear_out vectors.
REQ-002 Parameter CW, default 6: width of the cell-index field and counter (cells per line minus one).
REQ-003 Parameter LW, default 3: width of each line-index field and counter (line groups minus one).
REQ-004 Parameter LAT, default 9: multiplier drain latency in cycles, 1..255.
REQ-005 clk  in  1  clock; one clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high; clears all state.
REQ-007 enable  in  1  global enable; when low, all state holds, including counters, FSM and y_valid.
REQ-008 start  in  1  request new multiply; sampled only in IDLE.
REQ-009 cfg_wc  in  CW  cells per line minus one.
REQ-010 cfg_wl  in  LW  W line groups minus one.
REQ-011 cfg_xl  in  LW  X line groups minus one; independent of cfg_wl, for non-square operation.
REQ-012 cfg_mode  in  4  {transpose X, transpose W, ReLU, accumulate}.
REQ-013 clear_out  in  ARRAY  per-column result-ready flags from the multiplier.
REQ-014 busy  out  1  high in STREAM and DRAIN.
REQ-015 done  out  1  one-cycle completion pulse.
REQ-016 stream_en  out  1  operand beat valid; drives the multiplier enable.
REQ-017 w_switch, x_switch  out  1 each  memory line-advance strobes.
REQ-018 ind_wc  out  CW; ind_wl  out  LW; ind_xl  out  LW  current beat indices.
REQ-019 rd_mode_x, rd_mode_w  out  2 each  memory read modes.
REQ-020 wr_mode  out  3  write mode for the result page.
REQ-021 y_valid  out  ARRAY  registered write strobe.

Function
REQ-022 The FSM SHALL have states IDLE, STREAM, DRAIN and DONE; reset enters IDLE.
REQ-023 IDLE: start=1 SHALL latch all cfg_* into internal registers, zero all counters and enter STREAM; cfg_* SHALL be ignored at all other times.
REQ-024 start SHALL be ignored in STREAM, DRAIN and DONE.
REQ-025 STREAM: stream_en=1 every enabled cycle; one beat per cycle; the beat indices are the counters' values that cycle.
REQ-026 ind_wc SHALL increment each beat; w_switch=(ind_wc==wc); on w_switch, ind_wc wraps to 0 and ind_wl increments.
REQ-027 x_switch=(w_switch && ind_wl==wl); on x_switch, ind_wl wraps to 0 and ind_xl increments.
REQ-028 The last beat is (x_switch && ind_xl==xl); after it, all counters SHALL be 0 and the FSM enters DRAIN.
REQ-029 STREAM SHALL last exactly (wc+1)(wl+1)(xl+1) beats; all-zero cfg SHALL give exactly 1 beat with w_switch=x_switch=1.
REQ-030 w_switch and x_switch SHALL be 0 outside STREAM.
REQ-031 DRAIN SHALL last exactly LAT enabled cycles, counted by an 8-bit down-counter, then enter DONE.
REQ-032 DONE SHALL last 1 cycle with done=1, then enter IDLE; start is first accepted in the IDLE cycle after.
REQ-033 rd_mode_x SHALL be 3 if transpose X, else 1; rd_mode_w SHALL be 3 if transpose W, else 1; both SHALL be 0 when stream_en=0.
REQ-034 wr_mode SHALL be {1, accumulate?2'b10:2'b01} while busy and 0 otherwise.
REQ-035 y_valid SHALL be clear_out delayed one enabled cycle, in every state, so late results during DRAIN are captured.
REQ-036 enable low mid-STREAM SHALL pause without skipping or repeating beats, with stream_en and strobes held 0 while paused.

Reset
REQ-037 Reset SHALL take priority over enable and start.
REQ-038 Reset values: FSM=IDLE, counters=0, drain counter=0, y_valid=0, all outputs 0.
REQ-039 Reset mid-STREAM or mid-DRAIN SHALL abort with no done pulse.

Verification
REQ-040 wc=3, wl=1, xl=1, LAT=9, start sampled at edge 0 -> stream_en cycles 1-16; w_switch at 4, 8, 12, 16; x_switch at 8, 16; done at cycle 26 only.
REQ-041 wc=0, wl=0, xl=0 -> single beat at cycle 1 with w_switch=x_switch=1; done at cycle 1+LAT+1.
REQ-042 Non-square wc=2, wl=3, xl=0 -> 12 beats; ind_wl 0,0,0,1,1,1,2,2,2,3,3,3; x_switch only at beat 12.
REQ-043 enable=0 for 5 cycles after beat 6 -> beat 7 resumes with identical indices; done delayed by exactly 5 cycles.
REQ-044 start pulsed during STREAM with different cfg -> ignored; beat count and done timing unchanged.
REQ-045 Reset asserted at beat 3 -> next cycle all outputs 0 and FSM IDLE; no done pulse; a fresh start then runs normally.
